// File: rtl/cpu_serial_pkg.sv
// Shared definitions for the bit-serial CPU core: opcodes, FSM states, flag positions.
package cpu_serial_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_LDI  = 4'd7;
  localparam logic [3:0] OP_ADDI = 4'd8;
  localparam logic [3:0] OP_MOV  = 4'd9;
  localparam logic [3:0] OP_CMP  = 4'd10;
  localparam logic [3:0] OP_ROL  = 4'd11;
  localparam logic [3:0] OP_ROR  = 4'd12;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_EXEC, ST_DONE} state_t;

endpackage

// File: rtl/cpu_serial_alu.sv
// Combinational ALU: result, next flags and write enables for one decoded instruction.
// Rotate-through-carry ops exist only when CPU_SERIAL_CORE_ROTATE_EN is defined.
module cpu_serial_alu
  import cpu_serial_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  input  logic [3:0]        flags_in,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags_out,
  output logic              wr_rd,
  output logic              wr_res
);
  localparam int M = DATA_W - 1;

  logic [DATA_W-1:0] addend;
  logic [DATA_W:0]   sum, diff;
  logic              c, v, keep;

  always_comb begin
    addend = (op == OP_ADDI) ? imm : b;
    sum    = {1'b0, a} + {1'b0, addend};
    diff   = {1'b0, a} - {1'b0, b};
    result = a;
    c      = 1'b0;
    v      = 1'b0;
    keep   = 1'b0;
    wr_rd  = 1'b1;
    wr_res = 1'b1;
    case (op)
      OP_ADD, OP_ADDI: begin
        result = sum[M:0];
        c      = sum[DATA_W];
        v      = (a[M] == addend[M]) && (sum[M] != a[M]);
      end
      OP_SUB, OP_CMP: begin
        result = diff[M:0];
        c      = ~diff[DATA_W];
        v      = (a[M] != b[M]) && (diff[M] != a[M]);
        wr_rd  = (op == OP_SUB);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: begin result = {a[M-1:0], 1'b0}; c = a[M]; end
      OP_SHR: begin result = {1'b0, a[M:1]};   c = a[0]; end
      OP_LDI: begin result = imm; keep = 1'b1; end
      OP_MOV: begin result = b;   keep = 1'b1; end
`ifdef CPU_SERIAL_CORE_ROTATE_EN
      OP_ROL: begin result = {a[M-1:0], flags_in[FLAG_C]}; c = a[M]; end
      OP_ROR: begin result = {flags_in[FLAG_C], a[M:1]};   c = a[0]; end
`endif
      default: begin keep = 1'b1; wr_rd = 1'b0; wr_res = 1'b0; end
    endcase
    flags_out = keep ? flags_in : {result[M], v, (result == '0), c};
  end

endmodule

// File: rtl/cpu_serial_core.sv
// Bit-serial CPU: shifts in an MSB-first instruction frame, executes it on a small regfile.
// Optional rotate ops enabled by defining CPU_SERIAL_CORE_ROTATE_EN.
module cpu_serial_core
  import cpu_serial_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREG   = 4,
  localparam int RIDX_W = $clog2(NREG)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              bit_i,
  input  logic [RIDX_W-1:0] view_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [DATA_W-1:0] result_o,
  output logic [3:0]        flags_o,
  output logic [DATA_W-1:0] pc_o,
  output logic              busy_o,
  output logic              done_o
);
  localparam int FRAME_W = 4 + 2*RIDX_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W);

  state_t                       state;
  logic [FRAME_W-1:0]           frame;
  logic [CNT_W-1:0]             cnt;
  logic [NREG-1:0][DATA_W-1:0]  regs;

  logic [3:0]        op;
  logic [RIDX_W-1:0] rd, rs;
  logic [DATA_W-1:0] imm, alu_res;
  logic [3:0]        alu_flags;
  logic              wr_rd, wr_res;

  assign op  = frame[FRAME_W-1 -: 4];
  assign rd  = frame[DATA_W+2*RIDX_W-1 -: RIDX_W];
  assign rs  = frame[DATA_W+RIDX_W-1 -: RIDX_W];
  assign imm = frame[DATA_W-1:0];

  assign rdata_o = regs[view_i];

  // Operands are read before the EXEC edge, so rd==rs sees the old value on both ports.
  cpu_serial_alu #(.DATA_W(DATA_W)) u_alu (
    .op        (op),
    .a         (regs[rd]),
    .b         (regs[rs]),
    .imm       (imm),
    .flags_in  (flags_o),
    .result    (alu_res),
    .flags_out (alu_flags),
    .wr_rd     (wr_rd),
    .wr_res    (wr_res)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      frame    <= '0;
      cnt      <= '0;
      regs     <= '0;
      result_o <= '0;
      flags_o  <= '0;
      pc_o     <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_o <= 1'b0;
          cnt    <= '0;
          if (start_i) begin
            state  <= ST_SHIFT;
            busy_o <= 1'b1;
          end
        end
        ST_SHIFT: begin
          frame <= {frame[FRAME_W-2:0], bit_i};
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(FRAME_W-1)) state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (wr_rd)  regs[rd] <= alu_res;
          if (wr_res) result_o <= alu_res;
          flags_o <= alu_flags;
          pc_o    <= pc_o + DATA_W'(1);
          busy_o  <= 1'b0;
          done_o  <= 1'b1;
          state   <= ST_DONE;
        end
        default: begin
          done_o <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cpu_serial_core.md
CPU_SERIAL_CORE -- requirements
Module: cpu_serial_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8, datapath/register/PC width, legal 4..32.
REQ-002 SHALL have parameter NREG, default 4, register count, power of two 2..16; RIDX_W = log2(NREG).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk_i  in  1  sole clock, rising edge.
REQ-005 rst_i  in  1  asynchronous active-high reset.
REQ-006 start_i  in  1  begin serial instruction frame, sampled in IDLE only.
REQ-007 bit_i  in  1  serial frame bit, one per clock, MSB first.
REQ-008 view_i  in  RIDX_W  register index shown on rdata_o.
REQ-009 rdata_o  out  DATA_W  combinational read of register[view_i].
REQ-010 result_o  out  DATA_W  registered ALU result of last executed instruction.
REQ-011 flags_o  out  4  registered {N,V,Z,C}, bit 0 = C.
REQ-012 pc_o  out  DATA_W  instruction counter.
REQ-013 busy_o  out  1  high in SHIFT and EXEC.
REQ-014 done_o  out  1  one-cycle pulse on instruction completion.

Function
REQ-015 Frame SHALL be op[3:0], rd[RIDX_W], rs[RIDX_W], imm[DATA_W]; FRAME_W = 4+2*RIDX_W+DATA_W.
REQ-016 FSM states IDLE, SHIFT, EXEC, DONE; IDLE->SHIFT when start_i=1; SHIFT->EXEC after FRAME_W bits; EXEC->DONE; DONE->IDLE.
REQ-017 Timing: start_i sampled cycle 0; bits sampled cycles 1..FRAME_W; rd/flags/result_o/pc_o update at end of cycle FRAME_W+1; done_o high in cycle FRAME_W+2.
REQ-018 start_i outside IDLE SHALL be ignored; a new start_i is accepted in the cycle after DONE.
REQ-019 Opcodes: 0 ADD rd=rd+rs; 1 SUB rd=rd-rs; 2 AND; 3 OR; 4 XOR; 5 SHL rd=rd<<1; 6 SHR rd=rd>>1 logical; 7 LDI rd=imm; 8 ADDI rd=rd+imm; 9 MOV rd=rs; 10 CMP rd-rs, flags only; 11/12 per REQ-027; 13-15 NOP.
REQ-020 All arithmetic SHALL be modulo 2^DATA_W; C = carry-out (ADD/ADDI), NOT-borrow (SUB/CMP), shifted-out bit (SHL/SHR), 0 for logic ops.
REQ-021 V SHALL be signed overflow for ADD/ADDI/SUB/CMP, 0 otherwise; Z = result==0; N = result MSB.
REQ-022 LDI, MOV and NOP SHALL leave flags_o unchanged; NOP and CMP SHALL not write rd; result_o updates for every op except NOP.
REQ-023 pc_o SHALL increment by 1 per completed instruction incl. NOP, wrapping 2^DATA_W-1 -> 0.
REQ-024 rd==rs SHALL use the pre-write value of the register as both operands.

Reset
REQ-025 rst_i SHALL immediately force IDLE, clear all registers, result_o, flags_o, pc_o, shift counter; busy_o=0, done_o=0.
REQ-026 rst_i mid-frame SHALL discard the partial frame with no register, flag or PC effect after release.

Configuration
REQ-027 With CPU_SERIAL_CORE_ROTATE_EN defined, op 11 = ROL through C, op 12 = ROR through C, C = bit rotated out, Z/N updated, V=0; without it ops 11/12 SHALL behave as NOP.

Structure
REQ-028 Package cpu_serial_pkg SHALL hold opcode constants, FSM state type, flag bit indices.
REQ-029 Combinational ALU SHALL be sub-module cpu_serial_alu, parametrised by DATA_W; FSM, shifter, regfile and PC stay in cpu_serial_core.

Verification (DATA_W=8, NREG=4, FRAME_W=16)
REQ-030 Assert rst_i mid-cycle -> all outputs 0 before next clock edge; busy_o=0.
REQ-031 LDI R1,0x7F; LDI R2,0x01; ADD R1,R2 -> rdata_o[view=1]=0x80, flags_o=N1 V1 Z0 C0, pc_o=0x03, done_o pulse cycle 18 each.
REQ-032 LDI R0,0x05; SUB R0,R0 -> R0=0x00, Z=1, C=1, N=0, V=0; then CMP R0,R1(0x80 from REQ-031 sequence) -> R0 unchanged, C=0.
REQ-033 start_i held high throughout an instruction -> exactly one frame per IDLE entry, no extra done_o.
REQ-034 rst_i at bit 9 of LDI R3,0xAA frame -> R3=0x00, pc_o=0x00 after release; next full frame executes normally.
REQ-035 Macro defined: LDI R1,0x81, C=0, ROL R1 -> R1=0x02, C=1; macro undefined: same sequence -> R1=0x81, flags unchanged, pc_o increments.
